// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one
// iteration per cycle, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_div, r_neg, r_sa, r_done;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               w_sa, w_sb, w_last, w_ok, w_dz;
  logic [IW-1:0]      w_bi, w_ai;
  logic [WIDTH:0]     w_sum, w_t;
  logic [WIDTH-1:0]   w_rem, w_q, w_r, w_hi_fix, w_lo_fix;
  logic [2*WIDTH-1:0] w_mul, w_div, w_prod;
  assign w_sa   = ~op_i[0] & src_a_i[WIDTH-1];
  assign w_sb   = ~op_i[0] & src_b_i[WIDTH-1];
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // Operands stay intact for the whole run; bits are picked by counter so the
  // original dividend is still available for the divide-by-zero result.
  assign w_bi   = r_cnt[IW-1:0];
  assign w_ai   = IW'(WIDTH - 1) - r_cnt[IW-1:0];
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[w_bi] ? {1'b0, r_a} : '0);
  assign w_mul  = {w_sum, r_acc[WIDTH-1:1]};
  assign w_t    = {r_acc[2*WIDTH-1:WIDTH], r_a[w_ai]};
  assign w_ok   = w_t >= {1'b0, r_b};
  assign w_rem  = w_t[WIDTH-1:0] - r_b;
  assign w_div  = {w_ok ? w_rem : w_t[WIDTH-1:0], r_acc[WIDTH-2:0], w_ok};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_q    = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_dz   = r_b == '0;
  assign w_hi_fix = !r_div ? w_prod[2*WIDTH-1:WIDTH] : w_dz ? (r_sa ? -r_a : r_a) : w_r;
  assign w_lo_fix = !r_div ? w_prod[WIDTH-1:0] : w_dz ? '1 : w_q;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (start_i ? CALC : IDLE) :
             (r_state == CALC) ? (w_last ? FIX : CALC) : IDLE;
  end
  always_comb begin
    busy_o = r_state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_neg  <= 1'b0;
      r_sa   <= 1'b0;
      r_done <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_acc  <= '0;
    end else begin
      r_done <= r_state == FIX;
      if (r_state == IDLE && start_i) begin
        r_div <= op_i[1];
        r_neg <= w_sa ^ w_sb;
        r_sa  <= w_sa;
        r_a   <= w_sa ? -src_a_i : src_a_i;
        r_b   <= w_sb ? -src_b_i : src_b_i;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == IDLE) begin
        if (mthi_i) r_hi <= src_a_i;
        if (mtlo_i) r_lo <= src_a_i;
      end
      if (r_state == CALC) begin
        r_acc <= r_div ? w_div : w_mul;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIX) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table, corner sequences and randomized
// ops checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, mthi_i = 1'b0, mtlo_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] src_a_i = '0, src_b_i = '0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;
  logic [31:0] m_hi = '0, m_lo = '0;
  int checks = 0, failures = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    if (op == 2'd0) p = sa * sb;
    else if (op == 2'd1) p = {32'b0, a} * {32'b0, b};
    else if (b == 0) p = {a, 32'hFFFF_FFFF};
    else if (op == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end else p = {a % b, a / b};
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Called at a negedge; returns at the negedge where done_o is expected high.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic mv, input logic inj);
    int n = 0;
    bit stable = 1;
    start_i = 1; op_i = op; src_a_i = a; src_b_i = b; mtlo_i = mv;
    @(negedge clk);
    start_i = 0; mtlo_i = 0;
    while (busy_o && n < 100) begin
      n++;
      if (hi_o !== m_hi || lo_o !== m_lo || done_o !== 1'b0) stable = 0;
      if (inj && n == 5) begin
        start_i = 1; mthi_i = 1; op_i = ~op; src_a_i = $urandom; src_b_i = $urandom;
      end
      if (inj && n == 6) begin start_i = 0; mthi_i = 0; end
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 64'(n), 64'd33);
    chk({nm, " hold_during_calc"}, 64'(stable), 64'd1);
    chk({nm, " done"}, 64'(done_o), 64'd1);
    chk({nm, " hi"}, 64'(hi_o), 64'(eh));
    chk({nm, " lo"}, 64'(lo_o), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    vec_t vt[10];
    logic [31:0] eh, el, a, b;
    logic [1:0] op;
    bit seen;
    vt[0] = '{2'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vt[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000};
    vt[4] = '{2'd3, 32'd100,       32'd0,          32'h64,        32'hFFFF_FFFF};
    vt[5] = '{2'd3, 32'd100,       32'd7,          32'd2,         32'd14};
    vt[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7] = '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vt[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0};
    vt[9] = '{2'd0, 32'h0001_0000, 32'hFFFF_0000,  32'hFFFF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Consecutive table entries start in the done cycle of the previous op.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 1'b0, 1'b0);
    @(negedge clk);
    chk("done single pulse", 64'(done_o), 64'd0);

    mthi_i = 1; src_a_i = 32'h1234_5678;
    @(negedge clk);
    mthi_i = 0;
    chk("mthi hi", 64'(hi_o), 64'h1234_5678);
    chk("mthi lo kept", 64'(lo_o), 64'(m_lo));
    chk("mthi no done", 64'(done_o), 64'd0);
    m_hi = 32'h1234_5678;
    mtlo_i = 1; src_a_i = 32'hCAFE_F00D;
    @(negedge clk);
    mtlo_i = 0;
    chk("mtlo lo", 64'(lo_o), 64'hCAFE_F00D);
    m_lo = 32'hCAFE_F00D;
    mthi_i = 1; mtlo_i = 1; src_a_i = 32'h0BAD_BEEF;
    @(negedge clk);
    mthi_i = 0; mtlo_i = 0;
    chk("mthi+mtlo hi", 64'(hi_o), 64'h0BAD_BEEF);
    chk("mthi+mtlo lo", 64'(lo_o), 64'h0BAD_BEEF);
    m_hi = 32'h0BAD_BEEF; m_lo = 32'h0BAD_BEEF;

    run_op("start+mtlo", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
    model(2'd2, 32'hDEAD_BEEF, 32'h0000_1234, eh, el);
    run_op("inject busy", 2'd2, 32'hDEAD_BEEF, 32'h0000_1234, eh, el, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(0, 15));
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        mthi_i = 1; src_a_i = $urandom;
        @(negedge clk);
        mthi_i = 0;
        m_hi = src_a_i;
      end
      model(op, a, b, eh, el);
      run_op($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b, eh, el, 1'b0, 1'b0);
    end

    @(negedge clk);
    start_i = 1; op_i = 2'd0; src_a_i = 32'h1234_5678; src_b_i = 32'h9ABC_DEF0;
    @(negedge clk);
    start_i = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort busy", 64'(busy_o), 64'd0);
    chk("abort hi", 64'(hi_o), 64'd0);
    chk("abort lo", 64'(lo_o), 64'd0);
    seen = 0;
    repeat (40) begin
      if (done_o) seen = 1;
      @(negedge clk);
    end
    chk("abort no done", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
